// File: rtl/line_buffer_5row_if.sv
// Pixel-in / column-window-out bundle for line_buffer_5row.
// master: raster pixel source (drives pixels, consumes windows).
// slave:  the line buffer itself.
interface line_buffer_5row_if #(
    parameter int COL_W = 10
);
    logic [7:0]       pix_in;
    logic             pix_valid;
    logic             sof;
    logic [7:0]       pixel0;
    logic [7:0]       pixel1;
    logic [7:0]       pixel2;
    logic [7:0]       pixel3;
    logic [7:0]       pixel4;
    logic             out_valid;
    logic [COL_W-1:0] out_col;
    logic             out_last;

    modport master (
        output pix_in, pix_valid, sof,
        input  pixel0, pixel1, pixel2, pixel3, pixel4, out_valid, out_col, out_last
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output pixel0, pixel1, pixel2, pixel3, pixel4, out_valid, out_col, out_last
    );
endinterface

// File: rtl/line_buffer_5row.sv
// line_buffer_5row: raster-to-column window generator for a 5x5 filter.
// Four circular line memories hold the previous lines; each accepted pixel
// yields the five vertically aligned pixels of its column, one clock later.
// Optional feature macro: LB_ZERO_PAD_EN -- emit windows from row 0 with the
// rows above the frame top forced to zero.
module line_buffer_5row #(
    parameter int IMG_WIDTH = 512,
    parameter int COL_W     = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    line_buffer_5row_if.slave  bus
);

    localparam int               AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

    logic [7:0] l0 [IMG_WIDTH];
    logic [7:0] l1 [IMG_WIDTH];
    logic [7:0] l2 [IMG_WIDTH];
    logic [7:0] l3 [IMG_WIDTH];

    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_eff;
    logic [COL_W-1:0] col_nxt;
    logic [2:0]       rows;
    logic [2:0]       rows_eff;
    logic [2:0]       rows_nxt;
    logic             wrap;
    logic [AW-1:0]    addr;
    logic [7:0]       rd0, rd1, rd2, rd3;
    logic [7:0]       m0, m1, m2, m3;
    logic             win_ok;

    logic [7:0]       p0_q, p1_q, p2_q, p3_q, p4_q;
    logic             vld_q;
    logic [COL_W-1:0] col_q;
    logic             last_q;

    // Effective position of this pixel (sof overrides the counters), next counter values, memory read
    always_comb begin
        col_eff  = bus.sof ? '0 : col;
        rows_eff = bus.sof ? '0 : rows;
        wrap     = (col_eff == LAST_COL);
        col_nxt  = wrap ? '0 : col_eff + COL_W'(1);
        rows_nxt = (wrap && rows_eff != 3'd4) ? rows_eff + 3'd1 : rows_eff;
        addr     = col_eff[AW-1:0];
        rd0      = l0[addr];
        rd1      = l1[addr];
        rd2      = l2[addr];
        rd3      = l3[addr];
    end

`ifdef LB_ZERO_PAD_EN
    // Rows above the frame top read as zero; every accepted pixel yields a window
    always_comb begin
        m3     = (rows_eff >= 3'd1) ? rd0 : '0;
        m2     = (rows_eff >= 3'd2) ? rd1 : '0;
        m1     = (rows_eff >= 3'd3) ? rd2 : '0;
        m0     = (rows_eff >= 3'd4) ? rd3 : '0;
        win_ok = 1'b1;
    end
`else
    // Window is valid only once four earlier lines of this frame are stored
    always_comb begin
        m3     = rd0;
        m2     = rd1;
        m1     = rd2;
        m0     = rd3;
        win_ok = (rows_eff == 3'd4);
    end
`endif

    // Line memory shift at the current column; old data is read before it is overwritten
    always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
            l0[addr] <= bus.pix_in;
            l1[addr] <= rd0;
            l2[addr] <= rd1;
            l3[addr] <= rd2;
        end
    end

    // Counters and registered window; everything holds on idle cycles except out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            rows   <= '0;
            p0_q   <= '0;
            p1_q   <= '0;
            p2_q   <= '0;
            p3_q   <= '0;
            p4_q   <= '0;
            vld_q  <= 1'b0;
            col_q  <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q <= bus.pix_valid && win_ok;
            if (bus.pix_valid) begin
                col    <= col_nxt;
                rows   <= rows_nxt;
                p4_q   <= bus.pix_in;
                p3_q   <= m3;
                p2_q   <= m2;
                p1_q   <= m1;
                p0_q   <= m0;
                col_q  <= col_eff;
                last_q <= wrap;
            end
        end
    end

    assign bus.pixel0    = p0_q;
    assign bus.pixel1    = p1_q;
    assign bus.pixel2    = p2_q;
    assign bus.pixel3    = p3_q;
    assign bus.pixel4    = p4_q;
    assign bus.out_valid = vld_q;
    assign bus.out_col   = col_q;
    assign bus.out_last  = last_q;

endmodule

// File: tb/tb_line_buffer_5row.sv
// Self-checking bench for line_buffer_5row (IMG_WIDTH=8). A frame-coordinate
// image model predicts each window; predictions are queued when the pixel is
// driven and checked when out_valid appears. Honours LB_ZERO_PAD_EN.
module tb_line_buffer_5row;

    localparam int W  = 8;
    localparam int CW = 4;
`ifdef LB_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_buffer_5row_if #(.COL_W(CW)) bus ();

    line_buffer_5row #(.IMG_WIDTH(W), .COL_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0]    p0, p1, p2, p3, p4;
        logic [CW-1:0] col;
        logic          last;
    } win_t;

    typedef struct {
        int n;        // pixels in the stream
        int gap;      // idle cycles after each pixel
        int sof_at;   // extra sof position (-1: none)
        int cval;     // constant pixel value (-1: value = index)
        int exp_win;  // windows expected
    } scen_t;

    win_t   q[$];
    win_t   last_win;
    int     checks = 0;
    int     errors = 0;
    int     popped = 0;
    int     img [0:31][0:W-1];
    int     mx = 0;
    int     my = 0;

    // Scoreboard: every out_valid must match the oldest prediction
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            win_t act;
            act = '{bus.pixel0, bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4,
                    bus.out_col, bus.out_last};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL window_unexpected got %h want none", act);
            end else begin
                win_t e;
                e = q.pop_front();
                popped++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL window got %h want %h", act, e);
                end
            end
        end
    end

    task automatic drive_pix(input logic [7:0] v, input logic s);
        win_t e;
        int   yy;
        int   vals [5];
        if (s) begin
            mx = 0;
            my = 0;
        end
        img[my][mx] = int'(v);
        for (int k = 0; k < 5; k++) begin
            yy      = my - 4 + k;
            vals[k] = (yy < 0) ? 0 : img[yy][mx];
        end
        e = '{vals[0][7:0], vals[1][7:0], vals[2][7:0], vals[3][7:0], vals[4][7:0],
              CW'(mx), (mx == W - 1)};
        if (PAD || my >= 4) begin
            q.push_back(e);
            last_win = e;
        end
        bus.pix_in    = v;
        bus.pix_valid = 1'b1;
        bus.sof       = s;
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.pix_in    = 8'hxx;
        mx++;
        if (mx == W) begin
            mx = 0;
            if (my < 31) my++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_stream(input int n, input int gap, input int sof_at, input int cval);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            v = (cval >= 0) ? 8'(cval) : 8'(i);
            drive_pix(v, (i == 0) || (i == sof_at));
            idle(gap);
        end
    endtask

    // Window count plus idle-hold behaviour after a stream
    task automatic end_of_stream(input string name, input int exp_win);
        win_t act;
        idle(3);
        @(negedge clk);
        act = '{bus.pixel0, bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4,
                bus.out_col, bus.out_last};
        checks++;
        if (bus.out_valid !== 1'b0 || act !== last_win) begin
            errors++;
            $display("FAIL %s_hold got valid=%b win=%h want valid=0 win=%h",
                     name, bus.out_valid, act, last_win);
        end
        checks++;
        if (popped != exp_win || q.size() != 0) begin
            errors++;
            $display("FAIL %s_count got %0d windows (%0d pending) want %0d",
                     name, popped, q.size(), exp_win);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        scen_t tbl [4];
        logic [50:0] rst_act;

        tbl[0] = '{40, 0, -1, -1,  PAD ? 40 : 8};
        tbl[1] = '{40, 1, -1, -1,  PAD ? 40 : 8};
        tbl[2] = '{70, 0, 35, -1,  PAD ? 70 : 6};
        tbl[3] = '{48, 0, -1, 255, PAD ? 48 : 16};

        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        last_win      = '0;

        #12;
        rst_act = {bus.pixel0, bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4,
                   bus.out_valid, bus.out_col, bus.out_last};
        checks++;
        if (rst_act !== '0) begin
            errors++;
            $display("FAIL reset_state got %h want 0", rst_act);
        end
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            popped = 0;
            run_stream(tbl[i].n, tbl[i].gap, tbl[i].sof_at, tbl[i].cval);
            end_of_stream($sformatf("scen%0d", i), tbl[i].exp_win);
        end

        // Asynchronous reset mid-line, then a frame without sof
        popped = 0;
        run_stream(20, 0, -1, -1);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        rst_act = {bus.pixel0, bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4,
                   bus.out_valid, bus.out_col, bus.out_last};
        checks++;
        if (rst_act !== '0) begin
            errors++;
            $display("FAIL async_reset got %h want 0", rst_act);
        end
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mx     = 0;
        my     = 0;
        popped = 0;
        for (int i = 0; i < 40; i++) begin
            drive_pix(8'(100 + i), 1'b0);
        end
        end_of_stream("after_reset", PAD ? 40 : 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
